// File: rtl/rgb_fade_sequencer.sv
// HSV colour-wheel fade sequencer: six sectors, one channel ramps per sector, one step per PWM interval.
// Optional FADE_BRIGHTNESS_EN adds a registered global brightness scale on the three channel outputs.
module rgb_fade_sequencer #(
  parameter int PWM_INTERVAL = 1200,
  parameter int INC_DEC_MAX  = 200,
  localparam int W = $clog2(PWM_INTERVAL + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
`ifdef FADE_BRIGHTNESS_EN
  input  logic [7:0]   brightness,
`endif
  output logic [W-1:0] red_value,
  output logic [W-1:0] green_value,
  output logic [W-1:0] blue_value,
  output logic [2:0]   sector,
  output logic         step
);

  localparam int INC_DEC_VAL = PWM_INTERVAL / INC_DEC_MAX;
  localparam int IW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
  localparam int SW = (INC_DEC_MAX > 1) ? $clog2(INC_DEC_MAX) : 1;

  localparam logic [W-1:0]  FULL      = W'(PWM_INTERVAL);
  localparam logic [W-1:0]  STEP_V    = W'(INC_DEC_VAL);
  localparam logic [IW-1:0] INT_LAST  = IW'(PWM_INTERVAL - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(INC_DEC_MAX - 1);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } sector_e;

  sector_e       sector_q, sector_d;
  logic [W-1:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [IW-1:0] interval_cnt, interval_cnt_d;
  logic [SW-1:0] step_cnt, step_cnt_d;
  logic          tick, last_step, step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sector_q     <= S0;
      red_q        <= FULL;
      green_q      <= '0;
      blue_q       <= '0;
      interval_cnt <= '0;
      step_cnt     <= '0;
      step_q       <= 1'b0;
    end else begin
      sector_q     <= sector_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      interval_cnt <= interval_cnt_d;
      step_cnt     <= step_cnt_d;
      step_q       <= tick;
    end
  end

  // The last step of a sector loads the exact target so uneven step sizes cannot overshoot.
  always_comb begin
    tick           = en && (interval_cnt == INT_LAST);
    last_step      = (step_cnt == STEP_LAST);
    sector_d       = sector_q;
    red_d          = red_q;
    green_d        = green_q;
    blue_d         = blue_q;
    interval_cnt_d = interval_cnt;
    step_cnt_d     = step_cnt;

    if (en) interval_cnt_d = tick ? '0 : interval_cnt + IW'(1);

    if (tick) begin
      step_cnt_d = last_step ? '0 : step_cnt + SW'(1);
      case (sector_q)
        S0: begin
          green_d = last_step ? FULL : green_q + STEP_V;
          if (last_step) sector_d = S1;
        end
        S1: begin
          red_d = last_step ? '0 : red_q - STEP_V;
          if (last_step) sector_d = S2;
        end
        S2: begin
          blue_d = last_step ? FULL : blue_q + STEP_V;
          if (last_step) sector_d = S3;
        end
        S3: begin
          green_d = last_step ? '0 : green_q - STEP_V;
          if (last_step) sector_d = S4;
        end
        S4: begin
          red_d = last_step ? FULL : red_q + STEP_V;
          if (last_step) sector_d = S5;
        end
        S5: begin
          blue_d = last_step ? '0 : blue_q - STEP_V;
          if (last_step) sector_d = S0;
        end
        default: begin
          sector_d   = S0;
          red_d      = FULL;
          green_d    = '0;
          blue_d     = '0;
          step_cnt_d = '0;
        end
      endcase
    end
  end

  assign sector = sector_q;

`ifdef FADE_BRIGHTNESS_EN
  function automatic logic [W-1:0] scale_ch(input logic [W-1:0] v, input logic [7:0] b);
    logic [W+8:0] p;
    p = (W+9)'(v) * (W+9)'({1'b0, b} + 9'd1);
    return W'(p >> 8);
  endfunction

  // Scaled outputs add one register stage; step is delayed to match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_value   <= '0;
      green_value <= '0;
      blue_value  <= '0;
      step        <= 1'b0;
    end else begin
      red_value   <= scale_ch(red_q, brightness);
      green_value <= scale_ch(green_q, brightness);
      blue_value  <= scale_ch(blue_q, brightness);
      step        <= step_q;
    end
  end
`else
  assign red_value   = red_q;
  assign green_value = green_q;
  assign blue_value  = blue_q;
  assign step        = step_q;
`endif

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench for rgb_fade_sequencer using shrunken timing parameters (10-cycle interval, 4 steps/sector).
// Table vectors, hand-written corner sequences and a randomized run against an arithmetic wheel model.
module tb_rgb_fade_sequencer;

  localparam int PI   = 10;
  localparam int MAX  = 4;
  localparam int VAL  = PI / MAX;
  localparam int FULL = PI;
  localparam int W    = $clog2(PI + 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] red, green, blue;
  logic [2:0]   sec;
  logic         stp;
`ifdef FADE_BRIGHTNESS_EN
  logic [7:0]   brightness = 8'd255;
`endif

  int checks = 0;
  int errors = 0;
  int step_seen = 0;

  // Model state: enabled edges since reset release, and whether the last edge was a tick.
  int m_n = 0;
  bit m_step = 1'b0;

  rgb_fade_sequencer #(.PWM_INTERVAL(PI), .INC_DEC_MAX(MAX)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
`ifdef FADE_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .red_value(red),
    .green_value(green),
    .blue_value(blue),
    .sector(sec),
    .step(stp)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    int cycles;
    bit en;
    int exp_sector;
    int exp_r;
    int exp_g;
    int exp_b;
  } vec_t;

  vec_t vecs[9];

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Colour-wheel model: each channel is 0, FULL, rising or falling depending on the sector.
  function automatic int chanExp(input int n, input int ch);
    int t, s, k, role;
    int roles[3][6];
    roles[0] = '{1, 3, 0, 0, 2, 1};
    roles[1] = '{2, 1, 1, 3, 0, 0};
    roles[2] = '{0, 0, 2, 1, 1, 3};
    t = n / PI;
    s = (t / MAX) % 6;
    k = t % MAX;
    role = roles[ch][s];
    case (role)
      0: return 0;
      1: return FULL;
      2: return k * VAL;
      default: return FULL - k * VAL;
    endcase
  endfunction

  function automatic int sectorExp(input int n);
    return ((n / PI) / MAX) % 6;
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    m_n = 0;
    m_step = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input bit e, input int n);
    for (int i = 0; i < n; i++) begin
      en = e;
      @(posedge clk);
      m_step = e && ((m_n % PI) == PI - 1);
      if (e) m_n++;
      @(negedge clk);
      if (stp) step_seen++;
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "_sector"}, int'(sec), sectorExp(m_n));
    checkVal({tag, "_red"}, int'(red), chanExp(m_n, 0));
    checkVal({tag, "_green"}, int'(green), chanExp(m_n, 1));
    checkVal({tag, "_blue"}, int'(blue), chanExp(m_n, 2));
    checkVal({tag, "_step"}, int'(stp), int'(m_step));
  endtask

  initial begin
    int cnt;
    vecs[0] = '{0,   1'b1, 0, 10, 0,  0};
    vecs[1] = '{10,  1'b1, 0, 10, 2,  0};
    vecs[2] = '{20,  1'b1, 0, 10, 6,  0};
    vecs[3] = '{10,  1'b1, 1, 10, 10, 0};
    vecs[4] = '{25,  1'b0, 1, 10, 10, 0};
    vecs[5] = '{10,  1'b1, 1, 8,  10, 0};
    vecs[6] = '{30,  1'b1, 2, 0,  10, 0};
    vecs[7] = '{40,  1'b1, 3, 0,  10, 10};
    vecs[8] = '{120, 1'b1, 0, 10, 0,  0};

    // Table: walk once round the wheel, including a pause and the non-divisible last-step loads.
    doReset();
    step_seen = 0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].cycles);
      checkVal($sformatf("vec%0d_sector", i), int'(sec), vecs[i].exp_sector);
      checkVal($sformatf("vec%0d_red", i), int'(red), vecs[i].exp_r);
      checkVal($sformatf("vec%0d_green", i), int'(green), vecs[i].exp_g);
      checkVal($sformatf("vec%0d_blue", i), int'(blue), vecs[i].exp_b);
    end
    checkVal("wheel_step_pulses", step_seen, 6 * MAX);

    // First step pulse lands exactly one interval after release and lasts one cycle.
    doReset();
    applyStimulus(1'b1, PI - 1);
    checkVal("pre_tick_step", int'(stp), 0);
    checkVal("pre_tick_green", int'(green), 0);
    applyStimulus(1'b1, 1);
    checkVal("first_step", int'(stp), 1);
    checkVal("first_step_green", int'(green), VAL);
    applyStimulus(1'b1, 1);
    checkVal("step_one_cycle", int'(stp), 0);

    // Pause mid-interval delays the next step by the paused cycles.
    doReset();
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 7);
    cnt = 11;
    while (!stp && cnt < 100) begin
      applyStimulus(1'b1, 1);
      cnt++;
    end
    checkVal("paused_step_latency", cnt, 17);

    // en low during the tick cycle suppresses that tick.
    doReset();
    applyStimulus(1'b1, PI - 1);
    applyStimulus(1'b0, 1);
    checkVal("suppressed_step", int'(stp), 0);
    checkVal("suppressed_green", int'(green), 0);
    applyStimulus(1'b0, 3);
    checkVal("held_step", int'(stp), 0);
    applyStimulus(1'b1, 1);
    checkVal("resumed_step", int'(stp), 1);
    checkVal("resumed_green", int'(green), VAL);

    // Asynchronous reset in sector 3, mid-interval, between clock edges.
    doReset();
    applyStimulus(1'b1, 125);
    checkVal("pre_reset_sector", int'(sec), 3);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("async_rst_sector", int'(sec), 0);
    checkVal("async_rst_red", int'(red), FULL);
    checkVal("async_rst_green", int'(green), 0);
    checkVal("async_rst_blue", int'(blue), 0);
    checkVal("async_rst_step", int'(stp), 0);
    @(negedge clk);
    m_n = 0;
    m_step = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1'b1, PI);
    checkVal("post_rst_green", int'(green), VAL);
    checkVal("post_rst_sector", int'(sec), 0);

    // Randomized enable pattern with occasional resets, checked every cycle.
    doReset();
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 1);
      checkOutput("rand");
      if ($urandom_range(0, 999) == 0) begin
        doReset();
        checkOutput("rand_rst");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
